state_timer: RTL and testbench

- Consumer side of the per-state time parameter interface: watches `present_state` of the train controller FSM, samples the matching time value `t` (ms) and counts it down in real time.
- Signals the FSM with a one-cycle `expired` pulse when the dwell time for the current state has elapsed.
- Sits between the parameter lookup and the main controller FSM.
- Closes the loop: state goes out, time comes back, timeout returns to the FSM.

---
 rtl/state_timer.sv | 108 ++++++++++
 tb/tb_state_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/state_timer.sv
// Per-state dwell timer: reloads a millisecond countdown whenever the controller FSM changes
// state and returns a one-cycle expired pulse when the dwell time for that state has elapsed.
module state_timer #(
    parameter int unsigned CLK_FREQ_HZ  = 50000000,
    parameter int unsigned TICKS_PER_MS = CLK_FREQ_HZ / 1000,
    parameter int unsigned T_WIDTH      = 19,
    parameter int unsigned S_WIDTH      = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [S_WIDTH-1:0] present_state_i,
    input  logic [T_WIDTH-1:0] t_i,
    output logic               expired_o,
    output logic               busy_o,
    output logic [T_WIDTH-1:0] remaining_ms_o
);

    localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCount
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [S_WIDTH-1:0] state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [T_WIDTH-1:0] remaining_q, remaining_d;
    logic               expired_q, expired_d;
    logic               busy_q, busy_d;
    logic               chg;

    assign chg = (present_state_i != state_q);

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;

        // A state change overrides whatever the countdown was doing, including its final tick.
        if (chg) begin
            state_d = present_state_i;
            fsm_d   = StLoad;
            busy_d  = 1'b1;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                end
                StLoad: begin
                    remaining_d = t_i;
                    presc_d     = '0;
                    if (t_i == '0) begin
                        fsm_d  = StIdle;
                        busy_d = 1'b0;
                    end else begin
                        fsm_d = StCount;
                    end
                end
                StCount: begin
                    if (presc_q == PrescLast) begin
                        presc_d = '0;
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - 1'b1;
                        end
                        if (remaining_q <= T_WIDTH'(1)) begin
                            fsm_d     = StIdle;
                            busy_d    = 1'b0;
                            expired_d = (remaining_q == T_WIDTH'(1));
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    fsm_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            presc_q     <= '0;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
        end
    end

    assign expired_o      = expired_q;
    assign busy_o         = busy_q;
    assign remaining_ms_o = remaining_q;

endmodule

// File: tb/tb_state_timer.sv
// Bench for state_timer: directed scenarios plus random state/time/reset traffic, checked each
// cycle against a deadline-based model of the dwell timer.
module tb_state_timer;

    localparam int unsigned TICKS = 4;
    localparam int unsigned TW    = 19;
    localparam int unsigned SW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] ps;
    logic [TW-1:0] t;
    logic          expired;
    logic          busy;
    logic [TW-1:0] rem;

    int vectors     = 0;
    int miscompares = 0;

    // Model: a load fixes a deadline edge; remaining time is derived from elapsed edges.
    logic [SW-1:0] m_state;
    bit            m_pending, m_active, m_busy, m_exp;
    longint        m_rem, m_load_edge, m_n, edge_no;
    int            pulses;

    always #5 clk = ~clk;

    state_timer #(
        .CLK_FREQ_HZ (4000),
        .TICKS_PER_MS(TICKS),
        .T_WIDTH     (TW),
        .S_WIDTH     (SW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .present_state_i(ps),
        .t_i            (t),
        .expired_o      (expired),
        .busy_o         (busy),
        .remaining_ms_o (rem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic          r;
        logic [SW-1:0] p;
        logic [TW-1:0] tv;
        r  = rst_n;
        p  = ps;
        tv = t;
        @(posedge clk);
        edge_no++;
        m_exp = 1'b0;
        if (!r) begin
            m_state   = '0;
            m_pending = 1'b0;
            m_active  = 1'b0;
            m_busy    = 1'b0;
            m_rem     = 0;
        end else if (p != m_state) begin
            m_state   = p;
            m_pending = 1'b1;
            m_active  = 1'b0;
            m_busy    = 1'b1;
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_rem     = longint'(tv);
            if (tv == '0) begin
                m_busy = 1'b0;
            end else begin
                m_active    = 1'b1;
                m_load_edge = edge_no;
                m_n         = longint'(tv);
            end
        end else if (m_active) begin
            m_rem = m_n - (edge_no - m_load_edge) / TICKS;
            if (edge_no == m_load_edge + m_n * TICKS) begin
                m_active = 1'b0;
                m_busy   = 1'b0;
                m_exp    = 1'b1;
            end
        end
        #1;
        if (expired === 1'b1) pulses++;
        check("expired", 32'(expired), 32'(m_exp));
        check("busy", 32'(busy), 32'(m_busy));
        check("remaining_ms", 32'(rem), 32'(m_rem));
    endtask

    initial begin
        edge_no = 0;
        m_state = '0;
        m_pending = 1'b0;
        m_active = 1'b0;
        m_busy = 1'b0;
        m_exp = 1'b0;
        m_rem = 0;
        pulses = 0;

        // Reset held with a pending state/time on the inputs.
        rst_n = 1'b0;
        ps    = 4'b0011;
        t     = 19'd5;
        repeat (3) begin
            step();
            check("reset_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("post_reset_detect", 32'(busy), 32'd1);
        repeat (25) step();

        // Basic countdown 0 -> 0011, t=3.
        ps = 4'b0000;
        t  = 19'd0;
        repeat (3) step();
        ps = 4'b0011;
        t  = 19'd3;
        pulses = 0;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 1) check("basic_rem_k1", 32'(rem), 32'd3);
            if (i == 5) check("basic_rem_k5", 32'(rem), 32'd2);
            if (i == 9) check("basic_rem_k9", 32'(rem), 32'd1);
            if (i == 12) check("basic_no_early_exp", 32'(expired), 32'd0);
            if (i == 13) check("basic_exp_k13", 32'(expired), 32'd1);
            if (i == 14) check("basic_exp_k14", 32'(expired), 32'd0);
        end
        check("basic_one_pulse", 32'(pulses), 32'd1);

        // Zero time.
        ps = 4'b0110;
        t  = 19'd0;
        pulses = 0;
        step();
        step();
        check("zero_busy", 32'(busy), 32'd0);
        repeat (6) step();
        check("zero_no_pulse", 32'(pulses), 32'd0);

        // Abort at k+6 with a new state, t=1.
        ps = 4'b0011;
        t  = 19'd3;
        pulses = 0;
        repeat (6) step();
        ps = 4'b0100;
        t  = 19'd1;
        for (int i = 6; i <= 12; i++) begin
            step();
            if (i == 11) check("abort_exp_k11", 32'(expired), 32'd1);
        end
        check("abort_one_pulse", 32'(pulses), 32'd1);

        // Collision: state change on the final-decrement edge.
        ps = 4'b0101;
        t  = 19'd2;
        repeat (9) step();
        ps = 4'b0111;
        t  = 19'd1;
        step();
        check("coll_no_exp", 32'(expired), 32'd0);
        check("coll_rem_held", 32'(rem), 32'd1);
        check("coll_busy", 32'(busy), 32'd1);
        repeat (8) step();

        // Reset mid-count with remaining_ms=2.
        ps = 4'b0011;
        t  = 19'd3;
        repeat (6) step();
        check("midrst_pre_rem", 32'(rem), 32'd2);
        rst_n = 1'b0;
        step();
        check("midrst_rem", 32'(rem), 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_restart", 32'(busy), 32'd1);
        repeat (16) step();

        // Maximum time value: load and first decrements.
        ps = 4'b1001;
        t  = '1;
        repeat (10) step();
        check("max_rem", 32'(rem), 32'((1 << TW) - 3));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 9) == 0) ps = SW'($urandom);
            if ($urandom_range(0, 3) == 0) t = TW'($urandom_range(0, 4));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
